// File: rtl/l1pa_page_rotator_if.sv
// l1pa_page_rotator_if: page-in / rotated-page-out bundle for the L1 page-alignment stage
interface l1pa_page_rotator_if #(
  parameter int SHIFT_LENGTH = 15,
  parameter int SHIFT_W = 4
);
  logic [SHIFT_LENGTH-1:0] msgIn_bit3_i, msgIn_bit2_i, msgIn_bit1_i, msgIn_bit0_i;
  logic msgIn_valid_i, shift_load_i, isMsgPass_i;
  logic [SHIFT_W-1:0] shiftFactor_i;
  logic [SHIFT_LENGTH-1:0] l1paOut_bit3_o, l1paOut_bit2_o, l1paOut_bit1_o, l1paOut_bit0_o;
  logic [SHIFT_LENGTH-1:0] shiftROM_load_en_o;
  logic l1paOut_valid_o, layer_done_o, busy_o, seq_err_o;
  modport slave (
    input msgIn_bit3_i, msgIn_bit2_i, msgIn_bit1_i, msgIn_bit0_i, msgIn_valid_i,
    input shift_load_i, shiftFactor_i, isMsgPass_i,
    output l1paOut_bit3_o, l1paOut_bit2_o, l1paOut_bit1_o, l1paOut_bit0_o,
    output l1paOut_valid_o, shiftROM_load_en_o, layer_done_o, busy_o, seq_err_o
  );
  modport master (
    output msgIn_bit3_i, msgIn_bit2_i, msgIn_bit1_i, msgIn_bit0_i, msgIn_valid_i,
    output shift_load_i, shiftFactor_i, isMsgPass_i,
    input l1paOut_bit3_o, l1paOut_bit2_o, l1paOut_bit1_o, l1paOut_bit0_o,
    input l1paOut_valid_o, shiftROM_load_en_o, layer_done_o, busy_o, seq_err_o
  );
endinterface

// File: rtl/l1pa_page_rotator.sv
// l1pa_page_rotator: rotates each page by the layer's L1 shift factor, 2-cycle pipeline,
// and tracks page count per layer with a small IDLE/ACTIVE FSM.
module l1pa_page_rotator #(
  parameter int SHIFT_LENGTH = 15,
  parameter int PAGE_NUM = 51,
  parameter int QUAN_SIZE = 4,
  parameter int SHIFT_W = $clog2(SHIFT_LENGTH)
) (
  input logic sys_clk,
  input logic rstn,
  l1pa_page_rotator_if.slave bus
);
  localparam int CW = $clog2(PAGE_NUM);
  localparam logic [SHIFT_W:0] SL = (SHIFT_W+1)'(SHIFT_LENGTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [SHIFT_W-1:0] s_q, s_d, s_new, s_use, s1_q;
  logic idle, acc, first, last, load_ok, bad_sf, err_q, err_d;
  logic v1_q, f1_q, l1_q, v2_q, f2_q, l2_q;
  logic [3:0][SHIFT_LENGTH-1:0] pg_in, pg1_q, rot, out_q;
  logic [SHIFT_W:0] sum, lane;
  assign pg_in = {QUAN_SIZE > 3 ? bus.msgIn_bit3_i : '0, bus.msgIn_bit2_i, bus.msgIn_bit1_i, bus.msgIn_bit0_i};
  always_ff @(posedge sys_clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  // A load on the last page of a layer chains straight into the next layer.
  always_comb state_d = idle ? (bus.shift_load_i & ~last ? ACTIVE : IDLE)
                             : (~last | bus.shift_load_i ? ACTIVE : IDLE);
  always_comb begin
    idle = state_q == IDLE;
    acc = bus.msgIn_valid_i & (~idle | bus.shift_load_i);
    idx = idle ? '0 : cnt_q;
    first = acc & (idx == '0);
    last = acc & (idx == CW'(PAGE_NUM-1));
    load_ok = bus.shift_load_i & (idle | last);
    bad_sf = bus.isMsgPass_i & ({1'b0, bus.shiftFactor_i} >= SL);
    s_new = bus.isMsgPass_i & ~bad_sf ? bus.shiftFactor_i : '0;
    s_use = idle ? s_new : s_q;
    s_d = load_ok ? s_new : s_q;
    cnt_d = last ? '0 : idx + CW'(acc);
    err_d = err_q | (load_ok & bad_sf) | (bus.shift_load_i & ~load_ok) | (bus.msgIn_valid_i & ~acc);
  end
  // Lane index wraps by compare/subtract; i + s stays below 2*SHIFT_LENGTH.
  always_comb begin
    rot = '0;
    sum = '0;
    lane = '0;
    for (int i = 0; i < SHIFT_LENGTH; i++) begin
      sum = (SHIFT_W+1)'(i) + {1'b0, s1_q};
      lane = sum >= SL ? sum - SL : sum;
      for (int b = 0; b < 4; b++) rot[b][i] = pg1_q[b][lane[SHIFT_W-1:0]];
    end
  end
  always_ff @(posedge sys_clk or negedge rstn)
    if (!rstn) begin
      cnt_q <= '0;
      s_q <= '0;
      err_q <= 1'b0;
      v1_q <= 1'b0;
      f1_q <= 1'b0;
      l1_q <= 1'b0;
      s1_q <= '0;
      pg1_q <= '0;
      v2_q <= 1'b0;
      f2_q <= 1'b0;
      l2_q <= 1'b0;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      s_q <= s_d;
      err_q <= err_d;
      v1_q <= acc;
      f1_q <= first;
      l1_q <= last;
      if (acc) begin
        pg1_q <= pg_in;
        s1_q <= s_use;
      end
      v2_q <= v1_q;
      f2_q <= f1_q;
      l2_q <= l1_q;
      if (v1_q) out_q <= rot;
    end
  assign bus.l1paOut_bit3_o = out_q[3];
  assign bus.l1paOut_bit2_o = out_q[2];
  assign bus.l1paOut_bit1_o = out_q[1];
  assign bus.l1paOut_bit0_o = out_q[0];
  assign bus.l1paOut_valid_o = v2_q;
  assign bus.shiftROM_load_en_o = {SHIFT_LENGTH{f2_q}};
  assign bus.layer_done_o = l2_q;
  assign bus.busy_o = ~idle | v1_q | v2_q;
  assign bus.seq_err_o = err_q;
endmodule
